disp_scheduler: RTL

- Time-shares the 4-digit binary 7-segment display path (4-bit value into the per-bit digit decoder) among up to N_REQ requesters.
- Requesters post a 4-bit value with a valid/ack handshake. A round-robin arbiter grants one requester, and the value is shown for a fixed dwell time.
- An optional blank gap follows, with all segments off, before the next arbitration.
- Sits between the user-logic sources (switch banks, counters, ALU result) and the display decoder instance.

---
 rtl/disp_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/disp_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display time-share scheduler.
package disp_sched_pkg;

    typedef enum logic [1:0] {ARB, SHOW, BLANK} state_t;

    localparam int NIBBLE_W = 4;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority rotate: first set request at or after ptr, with wrap.
module rr_arbiter
    import disp_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   ptr,
    output logic [N-1:0]              gnt_onehot,
    output logic [idx_width(N)-1:0]   gnt_idx,
    output logic                      gnt_valid
);

    localparam int IW = idx_width(N);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Walk the requests from ptr upward, wrapping at N, and keep the first hit.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!gnt_valid && req[idx]) begin
                gnt_valid       = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_scheduler.sv
// Time-shares the 4-bit display value path among N_REQ requesters with
// round-robin arbitration, a fixed dwell time and an optional blank gap.
module disp_scheduler
    import disp_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int BLANK_CYCLES = 5_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [NIBBLE_W*N_REQ-1:0]     req_data,
    input  logic                          hold,
    output logic [N_REQ-1:0]              req_ack,
    output logic [NIBBLE_W-1:0]           disp_value,
    output logic                          disp_en,
    output logic [idx_width(N_REQ)-1:0]   disp_owner,
    output logic                          busy
);

    localparam int OW      = idx_width(N_REQ);
    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [OW-1:0]    LAST_IDX   = OW'(N_REQ - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  counter;
    logic [OW-1:0]     rr_ptr;
    logic              have_value;

    logic [N_REQ-1:0]  gnt_onehot;
    logic [OW-1:0]     gnt_idx;
    logic              gnt_valid;

    logic              dwell_done;
    logic              blank_done;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    assign dwell_done = !hold && (counter == DWELL_LAST);
    assign blank_done = (counter == BLANK_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: grant starts a slot, dwell ends it, blank (if any) separates slots.
    always_comb begin
        state_next = state;
        case (state)
            ARB:   if (gnt_valid) state_next = SHOW;
            SHOW:  if (dwell_done) state_next = (BLANK_CYCLES == 0) ? ARB : BLANK;
            BLANK: if (blank_done) state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    // Grant capture, phase counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter    <= '0;
            rr_ptr     <= '0;
            disp_value <= '0;
            disp_owner <= '0;
            req_ack    <= '0;
            have_value <= 1'b0;
        end else begin
            req_ack <= '0;
            case (state)
                ARB: begin
                    counter <= '0;
                    if (gnt_valid) begin
                        disp_value <= req_data[{gnt_idx, 2'b00} +: NIBBLE_W];
                        disp_owner <= gnt_idx;
                        req_ack    <= gnt_onehot;
                        rr_ptr     <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + OW'(1);
                        have_value <= 1'b1;
                    end
                end
                SHOW: begin
                    if (!hold) begin
                        counter <= dwell_done ? '0 : counter + CNT_W'(1);
                    end
                end
                BLANK: begin
                    counter <= blank_done ? '0 : counter + CNT_W'(1);
                end
                default: counter <= '0;
            endcase
        end
    end

    // Display enable and busy follow the phase; idle keeps the last value visible.
    always_comb begin
        disp_en = 1'b0;
        busy    = 1'b0;
        case (state)
            ARB:   disp_en = have_value;
            SHOW:  begin disp_en = 1'b1; busy = 1'b1; end
            BLANK: begin disp_en = 1'b0; busy = 1'b1; end
            default: begin disp_en = 1'b0; busy = 1'b0; end
        endcase
    end

endmodule
